dm_arbiter: RTL and testbench

//   Shares the single-port data memory (one write port, combinational read) between two

---
 rtl/dm_arbiter_if.sv | 56 +++++
 rtl/dm_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter_if
// Description : Bundles the two requester handshakes (m0 = CPU load/store,
//               m1 = DMA/debug) and the single-port data-memory bus.
//               Ports per requester N:
//                 mN_req/mN_we/mN_addr/mN_wd  requester -> arbiter
//                 mN_ack/mN_err/mN_rd         arbiter -> requester
//               Memory side:
//                 mem_we/mem_addr/mem_wd      arbiter -> memory
//                 mem_rd                      memory -> arbiter (comb. read)
//               Modport slave is the arbiter view; master is the view of
//               whatever drives the requesters and the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dm_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_ack;
    logic        m0_err;
    logic [31:0] m0_rd;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_ack;
    logic        m1_err;
    logic [31:0] m1_rd;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        output m0_ack, m0_err, m0_rd,
        input  m1_req, m1_we, m1_addr, m1_wd,
        output m1_ack, m1_err, m1_rd,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        input  m0_ack, m0_err, m0_rd,
        output m1_req, m1_we, m1_addr, m1_wd,
        input  m1_ack, m1_err, m1_rd,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Round-robin arbiter sharing one single-port data memory
//               between two requesters with a req/ack handshake and address
//               bounds checking. Each transaction runs IDLE -> ACCESS -> RESP.
//               Ports:
//                 clk  - system clock
//                 rst  - asynchronous active-high reset
//                 bus  - dm_arbiter_if.slave (requester handshakes + memory)
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int unsigned DEPTH    = 100,
    parameter logic [31:0] ERR_CODE = 32'hDEAD
) (
    input  wire logic   clk,
    input  wire logic   rst,
    dm_arbiter_if.slave bus
);

    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_ptr;       // requester that gets priority on a tie (0 = m0)
    logic        r_id;        // requester owning the current transaction
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic        r_in_range;  // compare resolved once, at latch time
    logic [31:0] r_rd0;
    logic [31:0] r_rd1;

    logic        w_any_req;
    logic        w_win_id;
    logic        w_win_we;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wd;
    logic [31:0] w_rd_value;

    // Winner selection: on a tie the pointer decides, otherwise the sole
    // requester wins (only-m1 yields 1, only-m0 yields 0).
    always_comb begin
        w_any_req  = bus.m0_req | bus.m1_req;
        w_win_id   = (bus.m0_req & bus.m1_req) ? r_ptr : bus.m1_req;
        w_win_we   = w_win_id ? bus.m1_we   : bus.m0_we;
        w_win_addr = w_win_id ? bus.m1_addr : bus.m0_addr;
        w_win_wd   = w_win_id ? bus.m1_wd   : bus.m0_wd;
        w_rd_value = r_in_range ? bus.mem_rd : ERR_CODE;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs. The memory strobe is decoded
    // straight from the state so an async reset removes it instantly.
    always_comb begin
        w_state_next = r_state;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h0;
        bus.mem_wd   = 32'h0;
        bus.m0_ack   = 1'b0;
        bus.m0_err   = 1'b0;
        bus.m1_ack   = 1'b0;
        bus.m1_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_next = S_RESP;
                bus.mem_we   = r_we & r_in_range;
                bus.mem_addr = r_addr;
                bus.mem_wd   = r_wd;
            end
            S_RESP: begin
                w_state_next = S_IDLE;
                bus.m0_ack   = ~r_id;
                bus.m0_err   = ~r_id & ~r_in_range;
                bus.m1_ack   = r_id;
                bus.m1_err   = r_id & ~r_in_range;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Transaction latch, priority pointer and per-requester read data.
    // Read data is captured at the end of ACCESS, so a write returns the
    // word's contents from before the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wd       <= 32'h0;
            r_in_range <= 1'b0;
            r_rd0      <= 32'h0;
            r_rd1      <= 32'h0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_id       <= w_win_id;
                r_ptr      <= ~w_win_id;
                r_we       <= w_win_we;
                r_addr     <= w_win_addr;
                r_wd       <= w_win_wd;
                r_in_range <= (w_win_addr < c_DEPTH);
            end
            if (r_state == S_ACCESS) begin
                if (r_id) begin
                    r_rd1 <= w_rd_value;
                end else begin
                    r_rd0 <= w_rd_value;
                end
            end
        end
    end

    assign bus.m0_rd = r_rd0;
    assign bus.m1_rd = r_rd1;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Self-checking bench for dm_arbiter: vector table, directed
//               multi-cycle sequences and a randomized phase scored against
//               a transaction-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int          DEPTH = 100;
    localparam logic [31:0] ERR   = 32'hDEAD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_arbiter_if bif();

    dm_arbiter #(.DEPTH(DEPTH), .ERR_CODE(ERR)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    // ------------------------------------------------------------------
    // Memory: combinational read, write on posedge, reloadable.
    // ------------------------------------------------------------------
    logic [31:0] mem       [DEPTH];
    logic [31:0] model_mem [DEPTH];
    logic        mem_load = 1'b1;

    function automatic logic [31:0] init_word(int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (bif.mem_we && (bif.mem_addr < 32'(DEPTH))) begin
            mem[bif.mem_addr[6:0]] <= bif.mem_wd;
        end
    end

    assign bif.mem_rd = (bif.mem_addr < 32'(DEPTH)) ? mem[bif.mem_addr[6:0]] : 32'h0;

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        n_checks++;
        if (act < 0 || act > lim) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected 0..%0d", name, act, lim);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (m == 0) begin
            bif.m0_req = req; bif.m0_we = we; bif.m0_addr = addr; bif.m0_wd = wd;
        end else begin
            bif.m1_req = req; bif.m1_we = we; bif.m1_addr = addr; bif.m1_wd = wd;
        end
    endtask

    function automatic logic ack_of(int m);
        return (m == 0) ? bif.m0_ack : bif.m1_ack;
    endfunction
    function automatic logic err_of(int m);
        return (m == 0) ? bif.m0_err : bif.m1_err;
    endfunction
    function automatic logic [31:0] rd_of(int m);
        return (m == 0) ? bif.m0_rd : bif.m1_rd;
    endfunction

    // Reset held over one posedge; memory and model reload together.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        mem_load = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_word(i);
        @(negedge clk);
        mem_load = 1'b0;
        rst      = 1'b0;
    endtask

    // One isolated transaction from IDLE. lat = negedges after the drive
    // edge until ack; we_mask bit c = mem_we seen at negedge c.
    task automatic run_txn(input int m, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, output logic err, output logic [31:0] rd,
                           output int lat, output logic [7:0] we_mask,
                           output int other_ack, output logic [31:0] rd_hold);
        err = 1'b0; rd = 32'h0; lat = -1; we_mask = 8'h0; other_ack = 0;
        drive(m, 1'b1, we, addr, wd);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (bif.mem_we) we_mask[c] = 1'b1;
            if (ack_of(1 - m)) other_ack++;
            if (ack_of(m)) begin
                lat = c; err = err_of(m); rd = rd_of(m);
                break;
            end
        end
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rd_hold = rd_of(m);
        if (bif.mem_we) we_mask[0] = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Randomized phase state and per-cycle scoring
    // ------------------------------------------------------------------
    logic        act   [2];
    logic        t_we  [2];
    logic [31:0] t_addr[2];
    logic [31:0] t_wd  [2];
    int          waitc [2];
    int          oth   [2];

    task automatic rnd_cycle(input bit allow_new);
        logic        a [2];
        logic        exp_err;
        logic [31:0] exp_rd;
        int          r;
        @(negedge clk);
        a[0] = bif.m0_ack;
        a[1] = bif.m1_ack;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rnd_m%0d_unrequested_ack", m), 32'(a[m] & ~act[m]), 32'h0);
            if (a[m] && act[m]) begin
                exp_err = (t_addr[m] >= 32'(DEPTH));
                exp_rd  = exp_err ? ERR : model_mem[t_addr[m][6:0]];
                check($sformatf("rnd_m%0d_err", m), 32'(err_of(m)), 32'(exp_err));
                check($sformatf("rnd_m%0d_rd", m), rd_of(m), exp_rd);
                check_le($sformatf("rnd_m%0d_other_served_first", m), oth[m], 1);
                if (!exp_err && t_we[m]) model_mem[t_addr[m][6:0]] = t_wd[m];
                act[m] = 1'b0;
            end else if (act[m]) begin
                if (a[1 - m]) oth[m]++;
                waitc[m]++;
                if (waitc[m] > 8) begin
                    n_checks++; n_fail++;
                    $display("FAIL rnd_m%0d_ack_timeout: waited %0d cycles, limit 8", m, waitc[m]);
                    act[m] = 1'b0;
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (!act[m] && allow_new && ($urandom_range(0, 2) == 0)) begin
                r = int'($urandom_range(0, 7));
                if (r == 0)      t_addr[m] = 32'(DEPTH);
                else if (r == 1) t_addr[m] = $urandom | 32'h8000_0000;
                else if (r == 2) t_addr[m] = 32'($urandom_range(0, 7));
                else             t_addr[m] = 32'($urandom_range(0, DEPTH - 1));
                t_we[m]  = 1'($urandom_range(0, 1));
                t_wd[m]  = $urandom;
                act[m]   = 1'b1;
                waitc[m] = 0;
                oth[m]   = 0;
                drive(m, 1'b1, t_we[m], t_addr[m], t_wd[m]);
            end else if (!act[m]) begin
                drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [7:0]  exp_mask;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        err;
        logic [31:0] rd, rd_hold;
        int          lat, other_ack, nack, cyc;
        logic [7:0]  mask;
        int          who [4];
        int          when[4];
        logic [31:0] rdv [4];
        int          bad_ack, mism;

        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int m = 0; m < 2; m++) begin
            act[m] = 1'b0; t_we[m] = 1'b0; t_addr[m] = 32'h0; t_wd[m] = 32'h0;
            waitc[m] = 0; oth[m] = 0;
        end

        vecs[0]  = '{0, 1'b1, 32'd5,          32'h1234, 1'b0, 32'hA000_0005, 8'h02};
        vecs[1]  = '{0, 1'b0, 32'd5,          32'h0,    1'b0, 32'h0000_1234, 8'h00};
        vecs[2]  = '{1, 1'b1, 32'd100,        32'h5555, 1'b1, ERR,           8'h00};
        vecs[3]  = '{1, 1'b1, 32'hFFFF_FFFF,  32'h6666, 1'b1, ERR,           8'h00};
        vecs[4]  = '{1, 1'b1, 32'd99,         32'h9999, 1'b0, 32'hA000_0063, 8'h02};
        vecs[5]  = '{1, 1'b0, 32'd99,         32'h0,    1'b0, 32'h0000_9999, 8'h00};
        vecs[6]  = '{0, 1'b0, 32'd100,        32'h0,    1'b1, ERR,           8'h00};
        vecs[7]  = '{1, 1'b0, 32'd0,          32'h0,    1'b0, 32'hA000_0000, 8'h00};
        vecs[8]  = '{0, 1'b1, 32'd0,          32'h0BAD, 1'b0, 32'hA000_0000, 8'h02};
        vecs[9]  = '{1, 1'b0, 32'd0,          32'h0,    1'b0, 32'h0000_0BAD, 8'h00};
        vecs[10] = '{1, 1'b1, 32'h8000_0064,  32'h7777, 1'b1, ERR,           8'h00};

        // Reset state
        @(negedge clk);
        check("rst_m0_ack", 32'(bif.m0_ack), 32'h0);
        check("rst_m1_ack", 32'(bif.m1_ack), 32'h0);
        check("rst_m0_err", 32'(bif.m0_err), 32'h0);
        check("rst_m1_err", 32'(bif.m1_err), 32'h0);
        check("rst_m0_rd", bif.m0_rd, 32'h0);
        check("rst_m1_rd", bif.m1_rd, 32'h0);
        check("rst_mem_we", 32'(bif.mem_we), 32'h0);
        check("rst_mem_addr", bif.mem_addr, 32'h0);
        check("rst_mem_wd", bif.mem_wd, 32'h0);

        // Table-driven single transactions
        do_reset();
        for (int v = 0; v < NVEC; v++) begin
            run_txn(vecs[v].m, vecs[v].we, vecs[v].addr, vecs[v].wd,
                    err, rd, lat, mask, other_ack, rd_hold);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'd2);
            check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
            check($sformatf("vec%0d_mem_we_cycles", v), 32'(mask), 32'(vecs[v].exp_mask));
            check($sformatf("vec%0d_loser_ack", v), 32'(other_ack), 32'h0);
            check($sformatf("vec%0d_rd_hold", v), rd_hold, vecs[v].exp_rd);
        end

        // Both request from reset and keep holding: m0,m1,m0,m1 every 3 cycles
        do_reset();
        drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
        nack = 0;
        for (int c = 1; c <= 20 && nack < 4; c++) begin
            @(negedge clk);
            if (bif.m0_ack || bif.m1_ack) begin
                who[nack]  = bif.m1_ack ? 1 : 0;
                when[nack] = c;
                rdv[nack]  = bif.m1_ack ? bif.m1_rd : bif.m0_rd;
                nack++;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rr_ack_count", 32'(nack), 32'd4);
        for (int k = 0; k < nack; k++) begin
            check($sformatf("rr_grant%0d_id", k), 32'(who[k]), 32'(k % 2));
            check($sformatf("rr_grant%0d_cycle", k), 32'(when[k]), 32'(2 + 3 * k));
            check($sformatf("rr_grant%0d_rd", k), rdv[k], init_word(1 + (k % 2)));
        end
        @(negedge clk);

        // Async reset during the ACCESS cycle of an m0 write
        do_reset();
        drive(0, 1'b1, 1'b1, 32'd7, 32'hFACE);
        @(negedge clk);
        check("abort_we_in_access", 32'(bif.mem_we), 32'h1);
        #1 rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("abort_we_drops", 32'(bif.mem_we), 32'h0);
        check("abort_addr_drops", bif.mem_addr, 32'h0);
        bad_ack = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            if (bif.m0_ack || bif.m1_ack) bad_ack++;
        end
        check("abort_no_ack", 32'(bad_ack), 32'h0);
        check("abort_mem_unchanged", mem[7], init_word(7));
        drive(0, 1'b1, 1'b0, 32'd8, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd9, 32'h0);
        cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bif.m0_ack || bif.m1_ack) begin
                cyc = bif.m0_ack ? c : -2;
                break;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("abort_next_grant_m0", 32'(cyc), 32'd2);
        @(negedge clk);

        // m1 holds req continuously; a single m0 request must not starve
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 1'b0, 32'd3, 32'h0);
            repeat (k) @(negedge clk);
            drive(0, 1'b1, 1'b0, 32'd4, 32'h0);
            lat = -1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (bif.m0_ack) begin
                    lat = c;
                    break;
                end
            end
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            check_le($sformatf("starve_k%0d_m0_latency", k), lat, 5);
            repeat (4) @(negedge clk);
        end

        // Fields changed during ACCESS are ignored
        drive(0, 1'b1, 1'b1, 32'd10, 32'h1111);
        @(negedge clk);
        check("latch_access_addr", bif.mem_addr, 32'd10);
        check("latch_access_wd", bif.mem_wd, 32'h1111);
        drive(0, 1'b1, 1'b1, 32'd11, 32'h2222);
        lat = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bif.m0_ack) begin
                lat = c;
                break;
            end
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("latch_ack_latency", 32'(lat), 32'd1);
        @(negedge clk);
        check("latch_mem10", mem[10], 32'h1111);
        check("latch_mem11", mem[11], init_word(11));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 12; c++) rnd_cycle(1'b0);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== model_mem[i]) mism++;
        check("rnd_final_memory_mismatches", 32'(mism), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
